// File: rtl/uart_tx.sv
// UART transmitter: pops one word per frame from a FIFO read port and serialises it
// as start bit, LSB-first data, optional parity and 1 or 2 stop bits.
module uart_tx #(
   parameter int DataWidth  = 8,
   parameter int ClksPerBit = 868,
   parameter int Parity     = 0,
   parameter int StopBits   = 1
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic                 i_en,
   input  logic [DataWidth-1:0] i_fifo_data,
   input  logic                 i_fifo_empty,
   output logic                 o_fifo_rd_en,
   output logic                 o_tx,
   output logic                 o_busy
);

   localparam int CntW = (ClksPerBit > 1) ? $clog2(ClksPerBit) : 1;
   localparam int IdxW = (DataWidth > 1) ? $clog2(DataWidth) : 1;
   localparam logic [CntW-1:0] CntLast = CntW'(ClksPerBit - 1);
   localparam logic [IdxW-1:0] IdxLast = IdxW'(DataWidth - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP
   } state_e;

   state_e               state_q;
   logic [CntW-1:0]      clk_cnt_q;
   logic [IdxW-1:0]      bit_idx_q;
   logic                 stop_idx_q;
   logic [DataWidth-1:0] shift_q;
   logic                 parity_q;
   logic                 tx_q;
   logic                 busy_q;

   logic bit_done;
   logic last_stop;
   logic pop;
   logic parity_d;

   assign bit_done  = (clk_cnt_q == CntLast);
   assign last_stop = (StopBits < 2) ? 1'b1 : stop_idx_q;
   // A new word is taken either from idle or in the very last cycle of the final stop bit
   assign pop       = i_en && !i_fifo_empty &&
                      ((state_q == S_IDLE) || ((state_q == S_STOP) && bit_done && last_stop));
   assign parity_d  = (^i_fifo_data) ^ (Parity == 2);

   assign o_fifo_rd_en = pop;
   assign o_tx         = tx_q;
   assign o_busy       = busy_q;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q    <= S_IDLE;
         clk_cnt_q  <= '0;
         bit_idx_q  <= '0;
         stop_idx_q <= 1'b0;
         shift_q    <= '0;
         parity_q   <= 1'b0;
         tx_q       <= 1'b1;
         busy_q     <= 1'b0;
      end else begin
         if (state_q != S_IDLE) begin
            clk_cnt_q <= bit_done ? '0 : clk_cnt_q + 1'b1;
         end
         case (state_q)
            S_IDLE: begin
               if (pop) begin
                  state_q   <= S_START;
                  clk_cnt_q <= '0;
                  shift_q   <= i_fifo_data;
                  parity_q  <= parity_d;
                  tx_q      <= 1'b0;
                  busy_q    <= 1'b1;
               end
            end
            S_START: begin
               if (bit_done) begin
                  state_q   <= S_DATA;
                  bit_idx_q <= '0;
                  tx_q      <= shift_q[0];
                  shift_q   <= shift_q >> 1;
               end
            end
            S_DATA: begin
               if (bit_done) begin
                  if (bit_idx_q == IdxLast) begin
                     if (Parity != 0) begin
                        state_q <= S_PARITY;
                        tx_q    <= parity_q;
                     end else begin
                        state_q    <= S_STOP;
                        stop_idx_q <= 1'b0;
                        tx_q       <= 1'b1;
                     end
                  end else begin
                     bit_idx_q <= bit_idx_q + 1'b1;
                     tx_q      <= shift_q[0];
                     shift_q   <= shift_q >> 1;
                  end
               end
            end
            S_PARITY: begin
               if (bit_done) begin
                  state_q    <= S_STOP;
                  stop_idx_q <= 1'b0;
                  tx_q       <= 1'b1;
               end
            end
            S_STOP: begin
               if (bit_done) begin
                  if (!last_stop) begin
                     stop_idx_q <= 1'b1;
                  end else if (pop) begin
                     state_q  <= S_START;
                     shift_q  <= i_fifo_data;
                     parity_q <= parity_d;
                     tx_q     <= 1'b0;
                  end else begin
                     state_q <= S_IDLE;
                     tx_q    <= 1'b1;
                     busy_q  <= 1'b0;
                  end
               end
            end
            default: begin
               state_q <= S_IDLE;
               tx_q    <= 1'b1;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: three builds (no parity / even parity / odd parity + 2 stop bits)
// checked cycle by cycle against a queue-of-line-levels reference model.
module tb_uart_tx;

   localparam int N   = 3;
   localparam int CPB = 4;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   logic       en     [N];
   logic [7:0] fdata  [N];
   logic       fempty [N];
   logic       rd_en  [N];
   logic       tx     [N];
   logic       busy   [N];

   logic [7:0] fifo_q   [N][$];
   bit         wave_q   [N][$];
   int         pop_t    [N][$];
   int         busy_cnt [N];

   int checks = 0;
   int errors = 0;
   int cycle  = 0;

   always #5 clk = ~clk;

   uart_tx #(.DataWidth(8), .ClksPerBit(CPB), .Parity(0), .StopBits(1)) u_dut0 (
      .i_clk(clk), .i_rst_n(rst_n), .i_en(en[0]), .i_fifo_data(fdata[0]),
      .i_fifo_empty(fempty[0]), .o_fifo_rd_en(rd_en[0]), .o_tx(tx[0]), .o_busy(busy[0]));
   uart_tx #(.DataWidth(8), .ClksPerBit(CPB), .Parity(1), .StopBits(1)) u_dut1 (
      .i_clk(clk), .i_rst_n(rst_n), .i_en(en[1]), .i_fifo_data(fdata[1]),
      .i_fifo_empty(fempty[1]), .o_fifo_rd_en(rd_en[1]), .o_tx(tx[1]), .o_busy(busy[1]));
   uart_tx #(.DataWidth(8), .ClksPerBit(CPB), .Parity(2), .StopBits(2)) u_dut2 (
      .i_clk(clk), .i_rst_n(rst_n), .i_en(en[2]), .i_fifo_data(fdata[2]),
      .i_fifo_empty(fempty[2]), .o_fifo_rd_en(rd_en[2]), .o_tx(tx[2]), .o_busy(busy[2]));

   function automatic int par_of(input int i);
      return (i == 0) ? 0 : ((i == 1) ? 1 : 2);
   endfunction

   function automatic int stops_of(input int i);
      return (i == 2) ? 2 : 1;
   endfunction

   function automatic int flen(input int i);
      return (1 + 8 + ((par_of(i) != 0) ? 1 : 0) + stops_of(i)) * CPB;
   endfunction

   task automatic check_val(input string tag, input int i, input logic [31:0] obs,
                            input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s dut%0d cycle %0d: got %0h expected %0h", tag, i, cycle, obs, exp);
      end
   endtask

   task automatic refresh();
      for (int i = 0; i < N; i++) begin
         fempty[i] = (fifo_q[i].size() == 0);
         fdata[i]  = fempty[i] ? 8'h00 : fifo_q[i][0];
      end
   endtask

   // Expected line levels for one whole frame, one entry per clock cycle
   task automatic add_frame(input int i, input logic [7:0] b);
      bit lv[$];
      lv.push_back(1'b0);
      for (int k = 0; k < 8; k++) lv.push_back(b[k]);
      if (par_of(i) != 0) lv.push_back((^b) ^ (par_of(i) == 2));
      for (int k = 0; k < stops_of(i); k++) lv.push_back(1'b1);
      foreach (lv[k]) begin
         for (int c = 0; c < CPB; c++) wave_q[i].push_back(lv[k]);
      end
   endtask

   // Called at posedge+1 after the caller has set this cycle's inputs
   task automatic step();
      #2;
      cycle++;
      for (int i = 0; i < N; i++) begin
         bit         exp_tx;
         bit         exp_busy;
         bit         exp_pop;
         logic [7:0] b;
         b = 8'h00;
         if (!rst_n) wave_q[i].delete();
         exp_busy = (wave_q[i].size() > 0);
         exp_tx   = exp_busy ? wave_q[i][0] : 1'b1;
         exp_pop  = rst_n && en[i] && (fifo_q[i].size() > 0) && (wave_q[i].size() <= 1);
         check_val("tx", i, 32'(tx[i]), 32'(exp_tx));
         check_val("busy", i, 32'(busy[i]), 32'(exp_busy));
         check_val("rd_en", i, 32'(rd_en[i]), 32'(exp_pop));
         if (busy[i] === 1'b1) busy_cnt[i]++;
         if (rd_en[i] === 1'b1) pop_t[i].push_back(cycle);
         if (exp_pop) b = fifo_q[i][0];
         if (wave_q[i].size() > 0) void'(wave_q[i].pop_front());
         if (exp_pop) add_frame(i, b);
         if ((rd_en[i] === 1'b1) && (fifo_q[i].size() > 0)) void'(fifo_q[i].pop_front());
      end
      @(posedge clk);
      #1;
      refresh();
   endtask

   task automatic run(input int n);
      for (int k = 0; k < n; k++) step();
   endtask

   task automatic clear_stats();
      for (int i = 0; i < N; i++) begin
         busy_cnt[i] = 0;
         pop_t[i].delete();
      end
   endtask

   task automatic push_all(input logic [7:0] b);
      for (int i = 0; i < N; i++) fifo_q[i].push_back(b);
      refresh();
   endtask

   task automatic set_en(input logic v);
      for (int i = 0; i < N; i++) en[i] = v;
   endtask

   initial begin
      set_en(1'b0);
      refresh();
      @(posedge clk);
      #1;
      run(3);
      rst_n = 1'b1;
      run(3);

      // single frame 0x55
      clear_stats();
      set_en(1'b1);
      push_all(8'h55);
      run(60);
      for (int i = 0; i < N; i++) begin
         check_val("t1_pops", i, 32'(pop_t[i].size()), 32'd1);
         check_val("t1_busy_cycles", i, 32'(busy_cnt[i]), 32'(flen(i)));
      end

      // back-to-back frames
      clear_stats();
      push_all(8'hA5);
      push_all(8'h3C);
      run(110);
      for (int i = 0; i < N; i++) begin
         check_val("t2_pops", i, 32'(pop_t[i].size()), 32'd2);
         if (pop_t[i].size() == 2)
            check_val("t2_spacing", i, 32'(pop_t[i][1] - pop_t[i][0]), 32'(flen(i)));
         check_val("t2_busy_cycles", i, 32'(busy_cnt[i]), 32'(2 * flen(i)));
      end

      // parity bit of 0x07 sits at frame cycles 36..39
      push_all(8'h07);
      step();
      run(37);
      check_val("t3_even_parity", 1, 32'(tx[1]), 32'd1);
      check_val("t3_odd_parity", 2, 32'(tx[2]), 32'd0);
      run(20);

      // empty FIFO with enable held
      clear_stats();
      run(100);
      for (int i = 0; i < N; i++) begin
         check_val("t4_pops", i, 32'(pop_t[i].size()), 32'd0);
         check_val("t4_busy_cycles", i, 32'(busy_cnt[i]), 32'd0);
      end

      // enable dropped during data bit 3
      push_all(8'hFF);
      push_all(8'h00);
      step();
      run(17);
      set_en(1'b0);
      run(60);
      for (int i = 0; i < N; i++) check_val("t5_fifo_left", i, 32'(fifo_q[i].size()), 32'd1);

      // reset in the middle of DATA
      for (int i = 0; i < N; i++) fifo_q[i].delete();
      set_en(1'b1);
      push_all(8'h5A);
      run(12);
      set_en(1'b0);
      rst_n = 1'b0;
      #1;
      for (int i = 0; i < N; i++) begin
         check_val("t6_tx_async", i, 32'(tx[i]), 32'd1);
         check_val("t6_busy_async", i, 32'(busy[i]), 32'd0);
      end
      run(3);
      rst_n = 1'b1;
      set_en(1'b1);
      clear_stats();
      run(40);
      for (int i = 0; i < N; i++) check_val("t6_idle_after", i, 32'(busy_cnt[i]), 32'd0);

      // randomized traffic
      for (int k = 0; k < 2500; k++) begin
         for (int i = 0; i < N; i++) begin
            if (($urandom_range(0, 7) == 0) && (fifo_q[i].size() < 3))
               fifo_q[i].push_back(8'($urandom()));
            if ($urandom_range(0, 39) == 0) en[i] = ~en[i];
         end
         refresh();
         step();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
